// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter with start/busy/done handshake
module bin2bcd_seq #(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [SW-1:0] sr, sr_n, sh;
  logic [BW-1:0] adj, bcd_n;
  logic [CW-1:0] cnt, cnt_n;
  logic load, last;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj[4*d +: 4] = sr[WIDTH+4*d +: 4] >= 4'd5 ? sr[WIDTH+4*d +: 4] + 4'd3 : sr[WIDTH+4*d +: 4];
  end
  // adjust-then-shift; binary MSB falls into scratch bit 0
  assign sh = {adj, sr[WIDTH-1:0]} << 1;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  always_comb begin
    load = state != SHIFT && start;
    last = state == SHIFT && cnt == CW'(WIDTH - 1);
    state_n = load ? SHIFT : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    sr_n = load ? {{BW{1'b0}}, bin} : state == SHIFT ? sh : sr;
    cnt_n = load ? '0 : state == SHIFT ? cnt + 1'b1 : cnt;
    bcd_n = last ? sh[SW-1 -: BW] : bcd;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      bcd <= '0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
      bcd <= bcd_n;
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and swept checks of bin2bcd_seq against a cycle-level decimal model
module tb_bin2bcd_seq;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] bin = 0;
  logic busy, done;
  logic [11:0] bcd;
  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  bit chk_en = 0;
  int m_left = 0, m_val = 0;
  logic m_done = 0;
  logic [11:0] m_bcd = 0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] conv(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // model: a conversion occupies WIDTH edges after acceptance, then one done cycle
  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_done = 0; m_bcd = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_bcd = conv(m_val);
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_val = int'(bin);
        m_left = 8;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("bcd", 32'(bcd), 32'(m_bcd));
    chk("busy_and_done", 32'(busy & done), 0);
    for (int i = 0; i < 3; i++) chk("digit_le9", 32'(bcd[4*i +: 4] <= 4'd9), 1);
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic convert(input int v, input logic [11:0] lit);
    int n;
    start = 1; bin = 8'(v);
    tick;
    start = 0; bin = 8'($urandom);
    wait_done(n);
    chk("latency", 32'(n), 8);
    chk("bcd_lit", 32'(bcd), 32'(lit));
    chk("model_lit", 32'(m_bcd), 32'(lit));
    tick;
    chk("done_falls", 32'(done), 0);
  endtask

  initial begin
    int n, d0;
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    tick; tick;
    reset = 0;
    chk_en = 1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bcd", 32'(bcd), 0);
    chk("conv_255", 32'(conv(255)), 32'h255);
    chk("conv_99", 32'(conv(99)), 32'h099);
    convert(0, 12'h000);
    convert(255, 12'h255);
    convert(128, 12'h128);
    convert(99, 12'h099);
    convert(9, 12'h009);
    // start and bin changes during SHIFT are ignored
    d0 = done_cnt;
    start = 1; bin = 200;
    tick;
    for (int i = 0; i < 7; i++) begin
      start = i[0]; bin = 17;
      tick;
    end
    start = 0;
    tick;
    chk("ign_done", 32'(done), 1);
    chk("ign_bcd", 32'(bcd), 32'h200);
    tick; tick; tick;
    chk("ign_pulses", 32'(done_cnt - d0), 1);
    // back-to-back with start held high
    start = 1; bin = 45;
    tick;
    bin = 67;
    wait_done(n);
    chk("b2b_lat1", 32'(n), 8);
    chk("b2b_bcd1", 32'(bcd), 32'h045);
    tick;
    chk("b2b_busy", 32'(busy), 1);
    start = 0;
    wait_done(n);
    chk("b2b_lat2", 32'(n + 1), 9);
    chk("b2b_bcd2", 32'(bcd), 32'h067);
    tick;
    // reset aborts a conversion
    convert(123, 12'h123);
    d0 = done_cnt;
    start = 1; bin = 250;
    tick;
    start = 0;
    tick; tick; tick;
    reset = 1;
    tick;
    reset = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_bcd", 32'(bcd), 0);
    for (int i = 0; i < 12; i++) tick;
    chk("abort_nodone", 32'(done_cnt - d0), 0);
    convert(250, 12'h250);
    for (int v = 0; v < 256; v++) convert(v, conv(v));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
